sram_rw_port_ctrl: RTL and testbench

Ready/valid request front-end for one single-port RW0-style SRAM macro: clock, addr, en, wmode, wmask, wdata, and rdata valid one cycle after a read. It sits between a cache/agent pipeline and the memory macro. It converts a decoupled request stream into RW0 port cycles and captures the one-cycle-late read data into a credit-protected response FIFO. Optionally it clears the whole array after reset before accepting traffic.

---
 rtl/sram_rw_port_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl: ready/valid request front-end for one single-port
// RW0-style SRAM macro (read data valid one cycle after the read cycle).
//
// Converts a decoupled request stream into RW0 port cycles and captures the
// one-cycle-late read data into a credit-protected response FIFO, so the
// FIFO can never overflow no matter how long the consumer stalls.
//
// Optional feature macro: SRAM_CTRL_INIT_CLEAR_EN
//   defined   -> after reset the whole array is written with zeros
//                (one word per cycle) before any request is accepted.
//   undefined -> no clear; the block is ready one edge after reset release.
//
// Ports
//   clock, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_write                 1 = write, 0 = read
//   req_addr/wmask/wdata      request payload
//   rsp_valid/rsp_ready       read response handshake
//   rsp_rdata                 read data, in request order
//   mem_en/wmode/addr/wmask/wdata  drive to the RW0 port
//   mem_rdata                 RW0 read data (valid one cycle after the read)
//   init_done                 array ready for traffic
module sram_rw_port_ctrl #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MASK_W    = 8,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_done
);

  localparam int unsigned PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(RSP_DEPTH + 1);
  localparam int unsigned CR_W     = CNT_W + 1;
  localparam int unsigned LAST_PTR = RSP_DEPTH - 1;

  // Registered state
  logic                r_init_done;
  logic                r_inflight;
  logic [CNT_W-1:0]    r_occ;
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [DATA_W-1:0]   r_fifo [RSP_DEPTH];

  // Combinational nets
  logic                w_init_sel;      // FSM is in the clear phase
  logic                w_init_we;       // clear-phase write this cycle
  logic [ADDR_W-1:0]   w_init_addr;
  logic                w_init_done_nxt;
  logic                w_issue;
  logic                w_rd_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_rsp_valid;
  logic [CR_W-1:0]     w_credits;

`ifdef SRAM_CTRL_INIT_CLEAR_EN
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_init_cnt;

  // State register and clear-address counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + ADDR_W'(1);
      end
    end
  end

  // Next state; the clear write is gated by reset_n so mem_en is 0 in reset
  always_comb begin
    w_state_nxt = r_state;
    w_init_sel  = 1'b0;
    w_init_we   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_sel = 1'b1;
        w_init_we  = reset_n;
        if (r_init_cnt == '1) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_init_addr     = r_init_cnt;
  assign w_init_done_nxt = (w_state_nxt == ST_RUN);
`else
  // No clear phase: ready from the first edge after reset release
  assign w_init_sel      = 1'b0;
  assign w_init_we       = 1'b0;
  assign w_init_addr     = '0;
  assign w_init_done_nxt = 1'b1;
`endif

  // init_done register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= w_init_done_nxt;
    end
  end

  // Credits count the pop happening this cycle, so a full FIFO being drained
  // still accepts one request per cycle (rsp_ready -> req_ready is comb).
  assign w_rsp_valid = (r_occ != '0);
  assign w_pop       = w_rsp_valid && rsp_ready;
  assign w_push      = r_inflight;
  assign w_credits   = CR_W'(RSP_DEPTH) - CR_W'(r_occ) - CR_W'(r_inflight)
                     + CR_W'(w_pop);

  assign req_ready   = r_init_done && (w_credits != '0);
  assign w_issue     = req_valid && req_ready;
  assign w_rd_issue  = w_issue && !req_write;

  // RW0 port drive: clear pattern during INIT, request pass-through otherwise
  always_comb begin
    mem_en    = w_init_we | w_issue;
    mem_wmode = req_write;
    mem_addr  = req_addr;
    mem_wmask = req_wmask;
    mem_wdata = req_wdata;
    if (w_init_sel) begin
      mem_wmode = 1'b1;
      mem_addr  = w_init_addr;
      mem_wmask = '1;
      mem_wdata = '0;
    end
  end

  // Read-inflight flag and FIFO occupancy / pointers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
      r_occ      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_inflight <= w_rd_issue;
      if (w_push && !w_pop) begin
        r_occ <= r_occ + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - CNT_W'(1);
      end
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_W'(LAST_PTR)) ? '0 : r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_W'(LAST_PTR)) ? '0 : r_rptr + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy qualifies them
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wptr] <= mem_rdata;
    end
  end

  assign rsp_valid = w_rsp_valid;
  assign rsp_rdata = r_fifo[r_rptr];
  assign init_done = r_init_done;

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Directed testbench for sram_rw_port_ctrl with a behavioural RW0 SRAM model.
module tb_sram_rw_port_ctrl;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned MASK_W    = 8;
  localparam int unsigned RSP_DEPTH = 2;
  localparam logic [63:0] GARBAGE   = 64'hDEAD_BEEF_0BAD_F00D;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_en;
  logic              mem_wmode;
  logic [ADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              init_done;

  int n_vec = 0;
  int n_err = 0;

  sram_rw_port_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .init_done(init_done)
  );

  always #5 clock = ~clock;

  // RW0 SRAM model: never-written words read back as a garbage pattern
  logic [63:0]  sram [0:511];
  logic [511:0] written = '0;
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) begin
        for (int g = 0; g < 8; g++) begin
          if (mem_wmask[g]) sram[mem_addr][g*8 +: 8] <= mem_wdata[g*8 +: 8];
        end
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? sram[mem_addr] : GARBAGE;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with reset_n low; returns once init_done is high
  task automatic release_reset();
    reset_n = 1'b1;
    #1;
    chk("init_done_at_release", 64'(init_done), 64'd0);
`ifdef SRAM_CTRL_INIT_CLEAR_EN
    chk("init_mem_en", 64'(mem_en), 64'd1);
    chk("init_req_ready", 64'(req_ready), 64'd0);
    repeat (511) @(negedge clock);
    #1;
    chk("init_done_511", 64'(init_done), 64'd0);
    @(negedge clock);
    #1;
    chk("init_done_512", 64'(init_done), 64'd1);
`else
    @(negedge clock);
    #1;
    chk("init_done_one_edge", 64'(init_done), 64'd1);
`endif
    chk("req_ready_after_init", 64'(req_ready), 64'd1);
  endtask

  task automatic do_write(input logic [8:0] a, input logic [7:0] m, input logic [63:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wmask = m; req_wdata = d;
    #1;
    chk("wr_ready", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  // Read with rsp_ready high; response expected exactly two cycles later
  task automatic do_read(input logic [8:0] a, input logic [63:0] exp, input string tag);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    chk({tag, "_n1_novalid"}, 64'(rsp_valid), 64'd0);
    @(negedge clock);
    #1;
    chk({tag, "_n2_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_data"}, rsp_rdata, exp);
    @(negedge clock);
    #1;
    chk({tag, "_popped"}, 64'(rsp_valid), 64'd0);
  endtask

  logic [63:0] exp_bp [4];
  logic [63:0] exp_st [16];

  initial begin : stim
    int acc;
    int got;
    logic acc_now;

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wmask = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    @(negedge clock);
    release_reset();

`ifdef SRAM_CTRL_INIT_CLEAR_EN
    do_read(9'h1FF, 64'd0, "clr_1ff");
    do_read(9'h000, 64'd0, "clr_000");
`endif

    // Write then read, then partial-mask overwrite
    do_write(9'h005, 8'hFF, 64'h1122_3344_5566_7788);
    do_read(9'h005, 64'h1122_3344_5566_7788, "rd_full");
    do_write(9'h005, 8'h0F, 64'h0);
    do_read(9'h005, 64'h1122_3344_0000_0000, "rd_mask");

    // Top address
    do_write(9'h1FF, 8'hFF, 64'hF00D_CAFE_A5A5_5A5A);
    do_read(9'h1FF, 64'hF00D_CAFE_A5A5_5A5A, "rd_top");

    // Back-pressure: 2 of 4 reads accepted while rsp_ready low, then drain
    for (int i = 0; i < 4; i++) begin
      exp_bp[i] = {32'hCAFE_0000 + 32'(i + 1), 32'h1234_0000 + 32'(i + 1)};
      do_write(9'(i + 1), 8'hFF, exp_bp[i]);
    end
    acc = 0; got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      rsp_ready = (cyc >= 6);
      req_valid = (acc < 4); req_write = 1'b0; req_addr = 9'(acc + 1);
      #1;
      acc_now = req_valid && req_ready;
      if (cyc == 5) begin
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_stalled", 64'(req_ready), 64'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (got < 4) chk("bp_rsp_data", rsp_rdata, exp_bp[got]);
        else         chk("bp_rsp_extra", 64'(got), 64'd3);
        got++;
      end
      @(negedge clock);
      if (acc_now) acc++;
    end
    req_valid = 1'b0;
    chk("bp_total_acc", 64'(acc), 64'd4);
    chk("bp_total_rsp", 64'(got), 64'd4);

    // Streaming: 16 back-to-back reads with rsp_ready held high
    for (int i = 0; i < 16; i++) begin
      exp_st[i] = {32'h5A5A_0000 | 32'(i), 32'(i * 3)};
      do_write(9'(9'h010 + 9'(i)), 8'hFF, exp_st[i]);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      req_valid = (c < 16); req_write = 1'b0; req_addr = 9'(9'h010 + 9'(c));
      #1;
      if (c < 16) chk("st_ready", 64'(req_ready), 64'd1);
      if (c >= 2) begin
        chk("st_valid", 64'(rsp_valid), 64'd1);
        chk("st_data", rsp_rdata, exp_st[c - 2]);
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    #1;
    chk("st_drained", 64'(rsp_valid), 64'd0);

    // Reset one cycle after a read is accepted
    @(negedge clock);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h005;
    #1;
    chk("mr_ready", 64'(req_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mr_mem_en", 64'(mem_en), 64'd0);
    chk("mr_req_ready", 64'(req_ready), 64'd0);
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_init_done", 64'(init_done), 64'd0);
    req_valid = 1'b0;
    @(negedge clock);
    release_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      #1;
      chk("mr_no_stale", 64'(rsp_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
